// File: rtl/spi_master.sv
// spi_master
//   SPI master sequencer. Shifts a parallel word out on sdo (MSB first) while
//   shifting the slave's reply in from sdi, then pulses done for one cycle.
//   The slave uses active-high select and captures on the sck rising edge.
//
// Ports
//   clk    system clock, all logic on the rising edge
//   rst    synchronous active-high reset, overrides every other input
//   start  transfer request; accepted only while idle
//   pdi    word to transmit, latched on the accept edge
//   pdo    last received word, updated only at done
//   busy   high while a transfer is in progress
//   done   one-cycle pulse at the end of a transfer
//   sck    serial clock, idle low
//   sdo    serial data to the slave, MSB first
//   sdi    serial data from the slave
//   scs    slave select, active high
//
// Parameters
//   size   word length in bits (>= 2)
//   div    sck half-period in clk cycles (>= 1)
//
// States
//   IDLE | waiting for start, sck/scs low
//   LOW  | sck low, sdo holds the current bit
//   HIGH | sck high, slave captures the bit
//   TAIL | scs held after the last sck fall (slave hold time)

module spi_master #(
    parameter int size = 8,
    parameter int div  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] pdi,
    output logic [size-1:0] pdo,
    output logic            busy,
    output logic            done,
    output logic            sck,
    output logic            sdo,
    input  logic            sdi,
    output logic            scs
);

    localparam int BW = $clog2(size + 1);
    // div = 1 would give a zero-width phase counter; keep at least one bit.
    localparam int PW = (div > 1) ? $clog2(div) : 1;
    localparam logic [PW-1:0] PH_RELOAD = PW'(div - 1);
    localparam logic [BW-1:0] BITS      = BW'(size);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        TAIL = 2'd3
    } state_t;

    state_t          state;
    logic [size-1:0] tx_sr;
    logic [size-1:0] rx_sr;
    logic [BW-1:0]   bit_cnt;
    logic [PW-1:0]   ph_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            ph_cnt  <= '0;
            pdo     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            scs     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sck  <= 1'b0;
                    scs  <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        tx_sr   <= pdi;
                        sdo     <= pdi[size-1];
                        scs     <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= BITS;
                        ph_cnt  <= PH_RELOAD;
                        state   <= LOW;
                    end
                end

                LOW: begin
                    if (ph_cnt == '0) begin
                        // Sample at the same edge that raises sck: the slave's
                        // data is still stable from the preceding low phase.
                        sck    <= 1'b1;
                        rx_sr  <= {rx_sr[size-2:0], sdi};
                        ph_cnt <= PH_RELOAD;
                        state  <= HIGH;
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end

                HIGH: begin
                    if (ph_cnt == '0) begin
                        sck     <= 1'b0;
                        bit_cnt <= bit_cnt - 1'b1;
                        ph_cnt  <= PH_RELOAD;
                        if (bit_cnt > BW'(1)) begin
                            tx_sr <= {tx_sr[size-2:0], 1'b0};
                            sdo   <= tx_sr[size-2];
                            state <= LOW;
                        end else begin
                            sdo   <= 1'b0;
                            state <= TAIL;
                        end
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end

                TAIL: begin
                    if (ph_cnt == '0) begin
                        scs   <= 1'b0;
                        busy  <= 1'b0;
                        pdo   <= rx_sr;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        ph_cnt <= ph_cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Clocked SPI master sequencer. It drives sck/sdo/scs toward an external or on-chip SPI slave, which uses active-high select, MSB first, and captures on the sck rising edge.
- The host side hands over one parallel word with a start strobe. The block shifts the word out while shifting the slave's reply in, then reports completion with a one-cycle done pulse.
- It sits between the FC100 control logic and any SPI peripheral, and generates all serial timing from the system clock.

Parameters:
size, 8, word length in bits (>=2)
div, 4, sck half-period in clk cycles (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  transfer request, sampled each clk
pdi  input  size  word to transmit, latched on accepted start
pdo  output  size  last received word
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse at transfer end
sck  output  1  serial clock, idle low
sdo  output  1  serial data to slave (slave sdi), MSB first
sdi  input  1  serial data from slave (slave sdo)
scs  output  1  slave select, active high

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high, and takes priority over every other input.
- Reset values, applied at the first clk edge with rst=1: sck=0, sdo=0, scs=0, busy=0, done=0, pdo=0, state=IDLE, counters=0.
- Reset mid-transfer aborts it at that edge:
  - scs, sck and sdo drop to 0.
  - No done pulse.
  - pdo is cleared.
- State machine states: IDLE, LOW, HIGH, TAIL.
- IDLE:
  - sck=0, scs=0, busy=0.
  - A clk edge with start=1 is the accept edge. It latches pdi into the tx shift register, sets scs=1, busy=1, sdo=pdi[size-1], bit counter=size, phase counter=div-1, and goes to LOW.
- LOW:
  - sck=0 for div cycles; sdo holds the current bit.
  - When the phase counter reaches 0: sck rises, sdi is sampled into the rx shift register LSB (rx shifts left), phase counter reloads, state goes to HIGH.
- HIGH:
  - sck=1 for div cycles.
  - When the phase counter reaches 0: sck falls and the bit counter decrements.
  - If bits remain: tx shifts left, sdo takes the next bit, state goes to LOW.
  - Otherwise: sdo=0, state goes to TAIL.
- TAIL:
  - scs held 1 and sck held 0 for div cycles (hold time for the slave).
  - On expiry: scs=0, busy=0, pdo loads the rx register, done=1 for exactly one cycle, state goes to IDLE.
- Latency: done is high in the cycle beginning exactly (2*size+1)*div clk edges after the accept edge. With size=8, div=4 that is 68 edges.
- Each transfer produces exactly size sck rising edges.
- sdo changes only while sck is low.
- scs rises at least div cycles before the first sck rise and falls div cycles after the last sck fall.
- start while busy=1 is ignored; it is neither queued nor latched. pdi may change freely during a transfer.
- Back-to-back: start=1 in the done cycle (state IDLE) is accepted. scs then stays low for exactly that one cycle between transfers.
- pdo is stable between done pulses; it changes only at a done edge or on reset.

Test Plan:
1. Loopback (sdo tied to sdi), size=8, div=4, start with pdi=0xA5 -> busy high next cycle; 8 sck rising edges; done pulses once, 68 edges after accept; pdo=0xA5; scs low after done.
2. Behavioural slave model returning 0x81 while pdi=0x5A -> slave captures 0x5A MSB-first on sck rises; pdo=0x81 at done.
3. start held high continuously, div=1, pdi=0x5A then 0xA5 switched at done -> two transfers of 17 edges each; scs low exactly 1 cycle between them; pdo=0x5A then 0xA5 (loopback).
4. Extra start pulses at cycles 5 and 30 of a transfer -> ignored; single done; sck rise count=8.
5. rst asserted at cycle 20 of a transfer -> next edge scs=0, sck=0, sdo=0, busy=0, pdo=0; no done; a subsequent start with 0x3C completes normally with pdo=0x3C.
6. start and rst high on the same edge -> block stays IDLE, busy=0, no sck activity.
